loopback_writer: RTL and testbench

LOOPBACK_WRITER -- requirements
Module: loopback_writer

---
 rtl/loopback_writer.sv | 189 ++++++++++++++++++
 tb/tb_loopback_writer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/loopback_writer.sv
// -----------------------------------------------------------------------------
// loopback_writer
//
// Drains cache lines from an upstream loopback FIFO and issues them as write
// requests to consecutive line addresses, starting at a latched base address.
// The number of writes awaiting completion is capped at MAX_OUTSTANDING. A
// transfer ends once every issued write has completed; done then pulses for
// one cycle.
//
// Ports
//   clk             sole clock, rising edge
//   reset           synchronous, active-high
//   start           one-cycle launch pulse, honoured only when idle
//   base_addr       line address of the first write
//   num_lines       number of lines to write (0 completes immediately)
//   fifo_data       upstream FIFO head entry, valid while fifo_empty=0
//   fifo_empty      upstream FIFO empty flag
//   fifo_deq        combinational dequeue strobe, high on every issue cycle
//   wr_req_valid    registered write-request valid
//   wr_req_addr     registered write-request line address
//   wr_req_data     registered write-request payload
//   wr_almost_full  write-channel backpressure; blocks issue while high
//   wr_rsp_valid    one write completion per asserted cycle
//   busy            high whenever the controller is not idle
//   done            one-cycle completion pulse
//   lines_written   completions received in the current transfer (saturating)
// -----------------------------------------------------------------------------
module loopback_writer #(
  parameter int DATA_WIDTH      = 512,
  parameter int ADDR_WIDTH      = 42,
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [31:0]           num_lines,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  output logic                  fifo_deq,
  output logic                  wr_req_valid,
  output logic [ADDR_WIDTH-1:0] wr_req_addr,
  output logic [DATA_WIDTH-1:0] wr_req_data,
  input  logic                  wr_almost_full,
  input  logic                  wr_rsp_valid,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           lines_written
);

  // One extra bit so the counter can hold MAX_OUTSTANDING itself.
  localparam int            CW      = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [31:0]             num_q, num_d;
  logic [31:0]             issued_q, issued_d;
  logic [CW-1:0]           outst_q, outst_d;
  logic [31:0]             lines_q, lines_d;
  logic                    wr_valid_q;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic                    busy_q, done_q;

  logic issue;
  logic rsp_accept;

  // Gated with reset so the upstream FIFO never loses an entry to a transfer
  // that is being abandoned in the same cycle.
  assign issue = !reset
              && (state_q == ST_RUN)
              && !fifo_empty
              && !wr_almost_full
              && (outst_q < MAX_CNT)
              && (issued_q < num_q);

  // A completion with nothing outstanding is stray (e.g. left over from a
  // transfer abandoned by reset) and is dropped.
  assign rsp_accept = wr_rsp_valid && (outst_q != '0);

  assign fifo_deq      = issue;
  assign wr_req_valid  = wr_valid_q;
  assign wr_req_addr   = wr_addr_q;
  assign wr_req_data   = wr_data_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign lines_written = lines_q;

  always_comb begin
    // NOTE: every variable assigned here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    state_d   = state_q;
    base_d    = base_q;
    num_d     = num_q;
    issued_d  = issued_q;
    outst_d   = outst_q;
    lines_d   = lines_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    // Simultaneous issue and completion cancel out.
    if (issue && !rsp_accept) begin
      outst_d = outst_q + 1'b1;
    end else if (!issue && rsp_accept) begin
      outst_d = outst_q - 1'b1;
    end

    if (rsp_accept && (lines_q != '1)) begin
      lines_d = lines_q + 32'd1;
    end

    // Address wraps naturally at ADDR_WIDTH bits.
    if (issue) begin
      issued_d  = issued_q + 32'd1;
      wr_addr_d = base_q + ADDR_WIDTH'(issued_q);
      wr_data_d = fifo_data;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d   = base_addr;
          num_d    = num_lines;
          issued_d = '0;
          outst_d  = '0;
          lines_d  = '0;
          state_d  = (num_lines != 32'd0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (issue && (issued_d == num_q)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Looks at the next-state count so the final completion moves us on
        // in the same cycle it arrives.
        if (outst_d == '0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      base_q     <= '0;
      num_q      <= '0;
      issued_q   <= '0;
      outst_q    <= '0;
      lines_q    <= '0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q    <= state_d;
      base_q     <= base_d;
      num_q      <= num_d;
      issued_q   <= issued_d;
      outst_q    <= outst_d;
      lines_q    <= lines_d;
      wr_valid_q <= issue;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= (state_d != ST_IDLE);
      done_q     <= (state_d == ST_DONE);
    end
  end

endmodule

// File: tb/tb_loopback_writer.sv
// -----------------------------------------------------------------------------
// tb_loopback_writer
//
// Scoreboard bench. Each transfer pushes its expected (address, data) writes
// -- base+i wrapped to ADDR_WIDTH bits, paired with the i-th word placed in the
// FIFO model -- onto queues; a monitor pops and compares on every
// wr_req_valid. An environment process models the upstream FIFO, the write
// channel backpressure and the completion path.
// -----------------------------------------------------------------------------
module tb_loopback_writer;

  localparam int DW      = 64;
  localparam int AW      = 42;
  localparam int MAX_OUT = 3;

  logic          clk            = 1'b0;
  logic          reset          = 1'b1;
  logic          start          = 1'b0;
  logic [AW-1:0] base_addr      = '0;
  logic [31:0]   num_lines      = '0;
  logic [DW-1:0] fifo_data      = '0;
  logic          fifo_empty     = 1'b1;
  logic          fifo_deq;
  logic          wr_req_valid;
  logic [AW-1:0] wr_req_addr;
  logic [DW-1:0] wr_req_data;
  logic          wr_almost_full = 1'b0;
  logic          wr_rsp_valid   = 1'b0;
  logic          busy;
  logic          done;
  logic [31:0]   lines_written;

  always #5 clk = ~clk;

  loopback_writer #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .MAX_OUTSTANDING(MAX_OUT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .base_addr     (base_addr),
    .num_lines     (num_lines),
    .fifo_data     (fifo_data),
    .fifo_empty    (fifo_empty),
    .fifo_deq      (fifo_deq),
    .wr_req_valid  (wr_req_valid),
    .wr_req_addr   (wr_req_addr),
    .wr_req_data   (wr_req_data),
    .wr_almost_full(wr_almost_full),
    .wr_rsp_valid  (wr_rsp_valid),
    .busy          (busy),
    .done          (done),
    .lines_written (lines_written)
  );

  int            n_checks = 0;
  int            n_fail   = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_data_q[$];
  logic [AW-1:0] exp_addr_q[$];
  int            rsp_due[$];
  int            wr_cyc[$];

  int            cyc         = 0;
  int            mcyc        = 0;
  int            wr_cnt      = 0;
  int            done_cnt    = 0;
  int            deq_cnt     = 0;
  int            due_v       = 0;
  int            release_cnt = 0;
  bit            rand_mode   = 1'b0;
  bit            rsp_hold    = 1'b0;
  bit            af_force    = 1'b0;
  bit            deq_s       = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Environment: FIFO model, backpressure and completions. Inputs change on
  // the falling edge; fifo_deq is sampled just before the rising edge.
  always begin
    @(negedge clk);
    cyc++;
    if (deq_s && fifo_q.size() > 0) void'(fifo_q.pop_front());
    check("valid_follows_deq", wr_req_valid, deq_s);

    if (wr_req_valid) begin
      due_v = cyc + (rand_mode ? int'($urandom_range(0, 4)) : 0);
      if (rsp_due.size() > 0 && rsp_due[$] > due_v) due_v = rsp_due[$];
      rsp_due.push_back(due_v);
    end

    wr_rsp_valid = 1'b0;
    if (rsp_due.size() > 0 && rsp_due[0] <= cyc && (!rsp_hold || release_cnt > 0)) begin
      void'(rsp_due.pop_front());
      wr_rsp_valid = 1'b1;
      if (rsp_hold) release_cnt--;
    end

    wr_almost_full = af_force || (rand_mode && $urandom_range(0, 3) == 0);
    fifo_empty     = (fifo_q.size() == 0) || (rand_mode && $urandom_range(0, 4) == 0);
    fifo_data      = (fifo_q.size() > 0) ? fifo_q[0] : '0;

    #4;
    deq_s = fifo_deq;
    if (fifo_deq) deq_cnt++;
    check("no_deq_when_empty", fifo_deq & fifo_empty, 1'b0);
    check("no_deq_when_almost_full", fifo_deq & wr_almost_full, 1'b0);
  end

  // Monitor: compares every presented write against the scoreboard.
  always @(negedge clk) begin
    mcyc++;
    if (done) done_cnt++;
    if (wr_req_valid) begin
      wr_cnt++;
      wr_cyc.push_back(mcyc);
      check("write_expected", exp_addr_q.size() > 0, 1'b1);
      if (exp_addr_q.size() > 0) begin
        check("wr_addr", wr_req_addr, exp_addr_q.pop_front());
        check("wr_data", wr_req_data, exp_data_q.pop_front());
      end
    end
  end

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"},          busy,          1'b0);
    check({tag, "_done"},          done,          1'b0);
    check({tag, "_wr_req_valid"},  wr_req_valid,  1'b0);
    check({tag, "_wr_req_addr"},   wr_req_addr,   '0);
    check({tag, "_wr_req_data"},   wr_req_data,   '0);
    check({tag, "_lines_written"}, lines_written, '0);
    check({tag, "_fifo_deq"},      fifo_deq,      1'b0);
  endtask

  // Reference model: line i of the transfer goes to base+i (mod 2^AW) and
  // carries the i-th word handed to the FIFO.
  task automatic load(input logic [AW-1:0] base, input int n);
    logic [DW-1:0] d;
    for (int i = 0; i < n; i++) begin
      d = {$urandom, $urandom};
      fifo_q.push_back(d);
      exp_data_q.push_back(d);
      exp_addr_q.push_back(base + AW'(i));
    end
  endtask

  task automatic launch(input logic [AW-1:0] base, input int n);
    load(base, n);
    @(negedge clk);
    base_addr = base;
    num_lines = 32'(n);
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({name, "_done_seen"}, got, 1'b1);
  endtask

  task automatic full_transfer(input string name, input logic [AW-1:0] base, input int n);
    bit got;
    int d0;
    d0 = done_cnt;
    launch(base, n);
    wait_done(name, 500, got);
    check({name, "_lines_written"}, lines_written, 32'(n));
    check({name, "_busy_at_done"}, busy, 1'b1);
    repeat (3) @(negedge clk);
    check({name, "_done_once"}, done_cnt - d0, 1);
    check({name, "_idle_after"}, busy, 1'b0);
    check({name, "_lw_hold"}, lines_written, 32'(n));
  endtask

  initial begin
    bit got;
    int w0, q0, span;
    logic [63:0] r;

    repeat (3) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b0;

    // Basic transfer, 1-cycle completions, back-to-back issue.
    w0 = wr_cnt;
    wr_cyc.delete();
    full_transfer("basic", AW'(42'h100), 4);
    check("basic_writes", wr_cnt - w0, 4);
    span = (wr_cyc.size() >= 4) ? (wr_cyc[3] - wr_cyc[0]) : -1;
    check("basic_back_to_back", span, 3);

    // Zero-length transfer.
    w0 = wr_cnt;
    q0 = deq_cnt;
    full_transfer("zero", AW'(42'h55), 0);
    check("zero_no_write", wr_cnt - w0, 0);
    check("zero_no_deq", deq_cnt - q0, 0);

    // Outstanding limit: completions withheld, then released one at a time.
    rsp_hold = 1'b1;
    w0 = wr_cnt;
    launch(AW'(42'h2000), 8);
    repeat (10) @(negedge clk);
    check("stall_issues", wr_cnt - w0, MAX_OUT);
    base_addr = AW'(42'h3FF);
    num_lines = 32'd1;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    for (int k = 1; k <= 2; k++) begin
      release_cnt = 1;
      repeat (6) @(negedge clk);
      check("stall_release", wr_cnt - w0, MAX_OUT + k);
    end
    rsp_hold = 1'b0;
    wait_done("stall", 500, got);
    check("stall_lines_written", lines_written, 32'd8);
    check("stall_writes", wr_cnt - w0, 8);
    repeat (3) @(negedge clk);

    // Five cycles of write-channel backpressure mid-transfer.
    w0 = wr_cnt;
    launch(AW'(42'h4000), 12);
    for (int i = 0; i < 50 && (wr_cnt - w0) < 3; i++) @(negedge clk);
    af_force = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i >= 1) check("af_no_write", wr_req_valid, 1'b0);
    end
    af_force = 1'b0;
    wait_done("af", 500, got);
    check("af_lines_written", lines_written, 32'd12);
    check("af_writes", wr_cnt - w0, 12);
    repeat (3) @(negedge clk);

    // Address wrap at 2^AW.
    full_transfer("wrap", {AW{1'b1}} - AW'(1), 4);

    // Reset mid-transfer, then stray completions.
    rsp_hold = 1'b1;
    w0 = wr_cnt;
    launch(AW'(42'h8000), 8);
    for (int i = 0; i < 50 && (wr_cnt - w0) < 3; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("pre_reset_outstanding", wr_cnt - w0, 3);
    reset = 1'b1;
    @(negedge clk);
    check_reset_state("midreset");
    fifo_q.delete();
    exp_addr_q.delete();
    exp_data_q.delete();
    @(negedge clk);
    reset    = 1'b0;
    rsp_hold = 1'b0;
    repeat (8) @(negedge clk);
    check("stray_lines_written", lines_written, 32'd0);
    check("stray_busy", busy, 1'b0);
    check("stray_no_write", wr_req_valid, 1'b0);
    full_transfer("after_reset", AW'(42'h9000), 5);

    // Randomised transfers with random backpressure, FIFO gaps and latency.
    rand_mode = 1'b1;
    for (int t = 0; t < 6; t++) begin
      r = {$urandom, $urandom};
      full_transfer("rand", r[AW-1:0], int'($urandom_range(1, 20)));
    end
    rand_mode = 1'b0;
    repeat (5) @(negedge clk);
    check("scoreboard_empty", exp_addr_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
